// File: rtl/countdown_min_sec.sv
// countdown_min_sec: loadable MM:SS countdown timer advanced by a 1 Hz strobe.
// Issues borrow_sec when seconds wrap 0 -> 59 and done_tmr on expiry.
// Optional build macro TIMER_AUTO_RELOAD_EN: on expiry the count reloads and
// the timer keeps running instead of entering EXPIRED.
module countdown_min_sec #(
    parameter int MAX_MIN = 59
) (
    input  logic       clock,
    input  logic       reset_tmr_n,
    input  logic [5:0] data_min,
    input  logic [5:0] data_sec,
    input  logic       load_tmr,
    input  logic       start_tmr,
    input  logic       stop_tmr,
    input  logic       tick_tmr,
    output logic [5:0] count_min,
    output logic [5:0] count_sec,
    output logic       borrow_sec,
    output logic       done_tmr,
    output logic       running_tmr,
    output logic       expired_tmr
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAUSE   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [5:0] MAX_MIN_C = 6'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_C = 6'd59;

    function automatic logic [5:0] clamp_sec(input logic [5:0] v);
        return (v > MAX_SEC_C) ? MAX_SEC_C : v;
    endfunction

    function automatic logic [5:0] clamp_min(input logic [5:0] v);
        return (v > MAX_MIN_C) ? MAX_MIN_C : v;
    endfunction

    logic [1:0] state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] rel_min_q, rel_min_d;
    logic [5:0] rel_sec_q, rel_sec_d;
    logic       borrow_q, borrow_d;
    logic       done_q, done_d;
    logic       running_q, expired_q;

    logic [5:0] ld_min, ld_sec;
    logic       ld_zero, rel_zero;

    assign ld_min   = clamp_min(data_min);
    assign ld_sec   = clamp_sec(data_sec);
    assign ld_zero  = (ld_min == 6'd0) && (ld_sec == 6'd0);
    assign rel_zero = (rel_min_q == 6'd0) && (rel_sec_q == 6'd0);

    // Next-state and next-count selection; inputs resolved in strict priority
    // load > stop > start > tick, so a masked lower input has no effect.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        rel_min_d = rel_min_q;
        rel_sec_d = rel_sec_q;
        borrow_d  = 1'b0;
        done_d    = 1'b0;
        if (load_tmr) begin
            min_d     = ld_min;
            sec_d     = ld_sec;
            rel_min_d = ld_min;
            rel_sec_d = ld_sec;
            state_d   = ld_zero ? ST_IDLE : ST_PAUSE;
        end else if (stop_tmr) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start_tmr) begin
            if (state_q == ST_PAUSE) begin
                state_d = ST_RUN;
            end else if (state_q == ST_EXPIRED) begin
                min_d   = rel_min_q;
                sec_d   = rel_sec_q;
                state_d = rel_zero ? ST_IDLE : ST_RUN;
            end
        end else if (tick_tmr && (state_q == ST_RUN)) begin
            if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
                // Final second: expire (or reload when auto-reload is built in)
                done_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                if (!rel_zero) begin
                    min_d   = rel_min_q;
                    sec_d   = rel_sec_q;
                    state_d = ST_RUN;
                end else begin
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                    state_d = ST_EXPIRED;
                end
`else
                min_d   = 6'd0;
                sec_d   = 6'd0;
                state_d = ST_EXPIRED;
`endif
            end else if (sec_q != 6'd0) begin
                sec_d = sec_q - 6'd1;
            end else if (min_q != 6'd0) begin
                sec_d    = MAX_SEC_C;
                min_d    = min_q - 6'd1;
                borrow_d = 1'b1;
            end
            // 00:00 while running cannot be reached; the count simply holds.
        end
    end

    // State, count, reload and registered status flags.
    always_ff @(posedge clock or negedge reset_tmr_n) begin
        if (!reset_tmr_n) begin
            state_q   <= ST_IDLE;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            rel_min_q <= 6'd0;
            rel_sec_q <= 6'd0;
            borrow_q  <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            rel_min_q <= rel_min_d;
            rel_sec_q <= rel_sec_d;
            borrow_q  <= borrow_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign count_min   = min_q;
    assign count_sec   = sec_q;
    assign borrow_sec  = borrow_q;
    assign done_tmr    = done_q;
    assign running_tmr = running_q;
    assign expired_tmr = expired_q;

endmodule

// File: tb/tb_countdown_min_sec.sv
// Scoreboard bench for countdown_min_sec: the driver pushes the expected
// outputs for every driven cycle; a monitor pops and compares after each edge.
module tb_countdown_min_sec;

    logic       clock = 1'b0;
    logic       reset_tmr_n = 1'b1;
    logic [5:0] data_min = 6'd0;
    logic [5:0] data_sec = 6'd0;
    logic       load_tmr = 1'b0;
    logic       start_tmr = 1'b0;
    logic       stop_tmr = 1'b0;
    logic       tick_tmr = 1'b0;
    logic [5:0] count_min, count_sec;
    logic       borrow_sec, done_tmr, running_tmr, expired_tmr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    countdown_min_sec #(.MAX_MIN(59)) dut (
        .clock       (clock),
        .reset_tmr_n (reset_tmr_n),
        .data_min    (data_min),
        .data_sec    (data_sec),
        .load_tmr    (load_tmr),
        .start_tmr   (start_tmr),
        .stop_tmr    (stop_tmr),
        .tick_tmr    (tick_tmr),
        .count_min   (count_min),
        .count_sec   (count_sec),
        .borrow_sec  (borrow_sec),
        .done_tmr    (done_tmr),
        .running_tmr (running_tmr),
        .expired_tmr (expired_tmr)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] outs();
        return {count_min, count_sec, borrow_sec, done_tmr, running_tmr, expired_tmr};
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d:%0d b%0b d%0b r%0b e%0b, want %0d:%0d b%0b d%0b r%0b e%0b",
                      nm, got[15:10], got[9:4], got[3], got[2], got[1], got[0],
                      exp[15:10], exp[9:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected outputs
    task automatic step(input string nm, input logic ld, input logic st, input logic sp,
                        input logic tk, input int dm, input int ds,
                        input int em, input int es, input logic b, input logic d,
                        input logic r, input logic e);
        @(negedge clock);
        load_tmr  = ld;
        start_tmr = st;
        stop_tmr  = sp;
        tick_tmr  = tk;
        data_min  = 6'(dm);
        data_sec  = 6'(ds);
        exp_q.push_back({6'(em), 6'(es), b, d, r, e});
        name_q.push_back(nm);
    endtask

    // Monitor: compare one queued expectation just after every rising edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) check(name_q.pop_front(), outs(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset_tmr_n = 1'b0;
        #2 check("reset_state", outs(), 16'd0);
        @(negedge clock);
        reset_tmr_n = 1'b1;

        //    name          ld st sp tk dm  ds   em es b d r e
        step("load_0102",   1, 0, 0, 0, 1,  2,   1, 2, 0,0,0,0);
        step("start",       0, 1, 0, 0, 0,  0,   1, 2, 0,0,1,0);
        step("tick1",       0, 0, 0, 1, 0,  0,   1, 1, 0,0,1,0);
        step("tick2",       0, 0, 0, 1, 0,  0,   1, 0, 0,0,1,0);
        step("tick3_borrow",0, 0, 0, 1, 0,  0,   0,59, 1,0,1,0);
        step("borrow_end",  0, 0, 0, 0, 0,  0,   0,59, 0,0,1,0);

        step("load_0002",   1, 0, 0, 0, 0,  2,   0, 2, 0,0,0,0);
        step("start2",      0, 1, 0, 0, 0,  0,   0, 2, 0,0,1,0);
        step("tick_01",     0, 0, 0, 1, 0,  0,   0, 1, 0,0,1,0);
`ifdef TIMER_AUTO_RELOAD_EN
        step("auto_reload", 0, 0, 0, 1, 0,  0,   0, 2, 0,1,1,0);
        step("auto_tick",   0, 0, 0, 1, 0,  0,   0, 1, 0,0,1,0);
        step("auto_hold",   0, 0, 0, 0, 0,  0,   0, 1, 0,0,1,0);
`else
        step("expire",      0, 0, 0, 1, 0,  0,   0, 0, 0,1,0,1);
        step("done_end",    0, 0, 0, 0, 0,  0,   0, 0, 0,0,0,1);
        step("tick_expired",0, 0, 0, 1, 0,  0,   0, 0, 0,0,0,1);
        step("restart",     0, 1, 0, 0, 0,  0,   0, 2, 0,0,1,0);
`endif
        step("load_clamp",  1, 0, 0, 0, 63,63,  59,59, 0,0,0,0);
        step("load_zero",   1, 0, 0, 0, 0,  0,   0, 0, 0,0,0,0);
        step("start_idle",  0, 1, 0, 0, 0,  0,   0, 0, 0,0,0,0);

        step("load_0010",   1, 0, 0, 0, 0, 10,   0,10, 0,0,0,0);
        step("start3",      0, 1, 0, 0, 0,  0,   0,10, 0,0,1,0);
        step("stop_tick",   0, 0, 1, 1, 0,  0,   0,10, 0,0,0,0);
        step("tick_pause",  0, 0, 0, 1, 0,  0,   0,10, 0,0,0,0);
        step("start_tick",  0, 1, 0, 1, 0,  0,   0,10, 0,0,1,0);
        step("tick_09",     0, 0, 0, 1, 0,  0,   0, 9, 0,0,1,0);
        step("tick_08",     0, 0, 0, 1, 0,  0,   0, 8, 0,0,1,0);
        step("tick_07",     0, 0, 0, 1, 0,  0,   0, 7, 0,0,1,0);
        step("tick_06",     0, 0, 0, 1, 0,  0,   0, 6, 0,0,1,0);
        step("tick_05",     0, 0, 0, 1, 0,  0,   0, 5, 0,0,1,0);

        // Asynchronous reset mid-count, between clock edges
        @(negedge clock);
        tick_tmr = 1'b0;
        #2 reset_tmr_n = 1'b0;
        #1 check("async_reset", outs(), 16'd0);
        @(negedge clock);
        reset_tmr_n = 1'b1;
        step("tick_after_rst", 0, 0, 0, 1, 0, 0,  0, 0, 0,0,0,0);
        step("tick_after_rst2",0, 0, 0, 1, 0, 0,  0, 0, 0,0,0,0);

        step("load_0003",   1, 0, 0, 0, 0,  3,   0, 3, 0,0,0,0);
        step("start4",      0, 1, 0, 0, 0,  0,   0, 3, 0,0,1,0);
        step("load_tick",   1, 0, 0, 1, 0,  7,   0, 7, 0,0,0,0);
        step("idle_end",    0, 0, 0, 0, 0,  0,   0, 7, 0,0,0,0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_min_sec.md
# countdown_min_sec

Loadable minutes:seconds countdown timer. It is the down-counting counterpart of the seconds up-counter chain: the up-counter issues a carry on wrap, and this block issues a borrow when seconds wrap from 0 to 59. It is advanced by a one-cycle 1 Hz strobe from the clock-divider and drives the timer display and alarm logic with count values and status flags.

## Interface
- MAX_MIN, default 59: largest loadable minutes value (1..63).
- clock  input  1  system clock; all registers update on the rising edge.
- reset_tmr_n  input  1  asynchronous, active-low reset.
- data_min  input  6  minutes preset, sampled on load_tmr.
- data_sec  input  6  seconds preset, sampled on load_tmr.
- load_tmr  input  1  load the presets into the count and reload registers.
- start_tmr  input  1  start or resume counting.
- stop_tmr  input  1  pause counting.
- tick_tmr  input  1  one-cycle 1 Hz decrement strobe.
- count_min  output  6  current minutes.
- count_sec  output  6  current seconds (0..59).
- borrow_sec  output  1  one-cycle pulse when seconds wrap from 0 to 59.
- done_tmr  output  1  one-cycle pulse on expiry.
- running_tmr  output  1  high while in RUN.
- expired_tmr  output  1  high while in EXPIRED.

## Operation
- States: IDLE, PAUSE, RUN, EXPIRED.
- Reset state: IDLE. Counts and reload registers are 0. All outputs are 0.
- Load clamping: data_sec > 59 loads as 59; data_min > MAX_MIN loads as MAX_MIN.
- Input priority, highest first: load_tmr, stop_tmr, start_tmr, tick_tmr.
- load_tmr, accepted in any state:
  - count and reload registers take the clamped presets;
  - next state is PAUSE if the loaded value is non-zero, otherwise IDLE;
  - a tick in the same cycle is discarded.
- start_tmr:
  - PAUSE -> RUN.
  - EXPIRED -> the count takes the reload value, then RUN; if the reload value is 00:00, the next state is IDLE instead.
  - Ignored in IDLE and RUN.
- stop_tmr:
  - RUN -> PAUSE. If a tick arrives in the same cycle, it is discarded.
  - Ignored in all other states.
- tick_tmr in RUN, with no higher-priority input asserted:
  - sec > 0: sec - 1.
  - sec == 0 and min > 0: sec <- 59, min <- min - 1, borrow_sec pulses.
  - Current value 00:01: the count becomes 00:00, done_tmr pulses, next state is EXPIRED.
- tick_tmr outside RUN is ignored.
- All arithmetic is 6-bit unsigned. Values never underflow below 00:00.

## Timing
- All outputs are registered.
- A tick sampled at rising edge N produces the new count and the borrow_sec/done_tmr pulses visible right after edge N. Each pulse lasts exactly one cycle.
- running_tmr and expired_tmr follow the state register in the same cycle as the state change.
- Asserting reset_tmr_n low forces IDLE and all outputs to 0 immediately, regardless of the clock, including mid-count.
- Back-to-back ticks on consecutive cycles each decrement the count.
- A start_tmr and tick_tmr in the same cycle in PAUSE: the block enters RUN and the tick is not applied.

## Configuration
- TIMER_AUTO_RELOAD_EN defined: the tick that would produce 00:00 instead loads the reload value and stays in RUN.
  - done_tmr still pulses.
  - EXPIRED is unreachable, and expired_tmr stays 0.
  - If the reload value is 00:00, the block enters EXPIRED as in the undefined case.
- TIMER_AUTO_RELOAD_EN undefined: behaviour is exactly as given under Operation.

## Test plan
- Reset, then load 01:02, start, 3 ticks -> count reads 01:01, 01:00, 00:59; borrow_sec pulses exactly once, on the third tick; running_tmr=1.
- Load 00:02, start, 2 ticks -> count reads 00:00; done_tmr pulses one cycle; expired_tmr=1; running_tmr=0. Further ticks leave the count at 00:00. Start -> count 00:02, RUN.
- Load data_min=63, data_sec=63 with MAX_MIN=59 -> count 59:59, state PAUSE. Load 00:00 -> state IDLE, and start_tmr has no effect.
- In RUN at 00:10, assert stop_tmr and tick_tmr together -> count stays 00:10, state PAUSE. A tick in PAUSE leaves the count at 00:10.
- In RUN at 00:05, drive reset_tmr_n low between clock edges -> all outputs are 0 immediately, IDLE. After release, ticks have no effect.
- TIMER_AUTO_RELOAD_EN defined: load 00:02, start, 2 ticks -> done_tmr pulses, count 00:02, running_tmr=1, expired_tmr=0.
